// File: rtl/serial_adder_n.sv
// Chunk-serial adder/subtractor: WIDTH-bit operands summed CHUNK bits per clock, LSB first.
// Optional `SERIAL_ADDER_OVF_EN adds a signed-overflow output (ovf).
module serial_adder_n #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int N     = WIDTH / CHUNK;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [WIDTH-1:0] CMASK = {WIDTH{1'b1}} >> (WIDTH - CHUNK);

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] opa;
  logic [WIDTH-1:0] opb;
  logic             carry;

  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [CHUNK:0]   res;
  logic [WIDTH-1:0] sum_nxt;
  logic             last;

  function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             c);
    return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  // Chunk datapath: select the current chunk of each operand and merge the result into sum
  always_comb begin
    a_sh    = opa >> (int'(cnt) * CHUNK);
    b_sh    = opb >> (int'(cnt) * CHUNK);
    res     = add_chunk(a_sh[CHUNK-1:0], b_sh[CHUNK-1:0], carry);
    sum_nxt = (sum & ~(CMASK << (int'(cnt) * CHUNK)))
            | (WIDTH'(res[CHUNK-1:0]) << (int'(cnt) * CHUNK));
    last    = (cnt == CNT_W'(N - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      sum   <= '0;
      cout  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            // Subtraction is a + ~b + 1: invert B once and seed the carry with 1
            opa   <= a;
            opb   <= sub ? ~b : b;
            carry <= sub | cin;
            cnt   <= '0;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          sum   <= sum_nxt;
          carry <= res[CHUNK];
          cnt   <= cnt + 1'b1;
          if (last) begin
            cout  <= res[CHUNK];
`ifdef SERIAL_ADDER_OVF_EN
            // Carry into the MSB recovered from its sum bit and operand bits
            ovf   <= (opa[WIDTH-1] ^ opb[WIDTH-1] ^ res[CHUNK-1]) ^ res[CHUNK];
`endif
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy = (state == RUN);
  assign done = (state == DONE);

endmodule

// File: tb/tb_serial_adder_n.sv
// Directed self-checking bench for serial_adder_n at WIDTH=8, CHUNK=2 (four chunks per operation).
module tb_serial_adder_n;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       sub = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic       busy;
  logic       done;
  logic [7:0] sum;
  logic       cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic       ovf;
`endif

  int n_cmp = 0;
  int n_err = 0;

  serial_adder_n #(.WIDTH(8), .CHUNK(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .sub  (sub),
    .a    (a),
    .b    (b),
    .cin  (cin),
    .busy (busy),
    .done (done),
    .sum  (sum),
    .cout (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf  (ovf)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int max, output int n);
    n = 0;
    while (done !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Launch one operation from idle, check busy/latency and the final result
  task automatic run_op(input string tag, input logic [7:0] ia, input logic [7:0] ib,
                        input logic ic, input logic is, input logic [7:0] es,
                        input logic ec, input logic eo);
    int n;
    a = ia; b = ib; cin = ic; sub = is; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    wait_done(10, n);
    chk({tag, "_lat"}, 32'(n), 32'd4);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
`ifdef SERIAL_ADDER_OVF_EN
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
`else
    if (eo === 1'bx) $display("note: unreachable");
`endif
    @(negedge clk);
    chk({tag, "_pulse"}, 32'(done), 32'd0);
  endtask

  initial begin
    int n;
    int ndone;

    // Reset then idle
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("idle", 32'({busy, done, sum, cout}), 32'd0);
    end

    run_op("addwrap", 8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    run_op("sub57",   8'h05, 8'h07, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_op("sub7f80", 8'h7F, 8'h80, 1'b0, 1'b1, 8'hFF, 1'b0, 1'b1);

    // Signed overflow with a start request arriving mid-run
    a = 8'h7F; b = 8'h01; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 8'h11; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0;
    repeat (8) begin
      if (done) begin
        ndone++;
        if (ndone == 1) begin
          chk("ovfadd_sum", 32'(sum), 32'h80);
          chk("ovfadd_cout", 32'(cout), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
          chk("ovfadd_ovf", 32'(ovf), 32'd1);
`endif
        end
      end
      @(negedge clk);
    end
    chk("ovfadd_ndone", 32'(ndone), 32'd1);

    // Back-to-back: second start held through the DONE cycle
    a = 8'h01; b = 8'h02; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(10, n);
    chk("b2b_first_sum", 32'(sum), 32'h03);
    a = 8'h10; b = 8'h20; cin = 1'b1; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("b2b_busy", 32'(busy), 32'd1);
    wait_done(10, n);
    chk("b2b_gap", 32'(n + 1), 32'd5);
    chk("b2b_sum", 32'(sum), 32'h31);
    chk("b2b_cout", 32'(cout), 32'd0);
    @(negedge clk);

    // Reset mid-operation
    a = 8'h55; b = 8'h00; cin = 1'b0; sub = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midrst_clear", 32'({busy, done, sum, cout}), 32'd0);
    ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (done) ndone++;
    end
    chk("midrst_nodone", 32'(ndone), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("afterrst", 8'h03, 8'h04, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised, multi-cycle, chunk-serial adder/subtractor.
- Generalises the single-bit registered full adder to WIDTH-bit operands, processed CHUNK bits per clock from the LSB upward, with a registered carry between chunks.
- Start/busy/done handshake; used as an area-lean datapath adder in the processor's multi-cycle units.

Parameters:
- WIDTH, 8, operand and result width in bits; must be an integer multiple of CHUNK.
- CHUNK, 2, bits added per clock; 1 <= CHUNK <= WIDTH.

Ports:
- clk, input, 1, rising-edge clock.
- rst_n, input, 1, asynchronous active-low reset.
- start, input, 1, request a new operation; sampled on rising clk.
- sub, input, 1, 0 = add, 1 = subtract; latched with start.
- a, input, WIDTH, operand A; latched with start.
- b, input, WIDTH, operand B; latched with start.
- cin, input, 1, carry-in for add; ignored when sub=1.
- busy, output, 1, high while an operation is in progress.
- done, output, 1, one-cycle pulse when sum/cout become valid.
- sum, output, WIDTH, result.
- cout, output, 1, carry-out (add) or not-borrow (sub).

Behaviour:
- Reset (async, rst_n=0): state=IDLE; busy=0, done=0, sum=0, cout=0; internal operand, carry and chunk-counter registers cleared. Asserting reset mid-operation aborts the operation with no done pulse.
- Define N = WIDTH/CHUNK.
- FSM states: IDLE, RUN, DONE.
- IDLE or DONE, start=1 at an edge:
  - latch a, b and sub;
  - latch the carry register = sub ? 1 : cin;
  - latch the effective B = sub ? ~b : b;
  - counter=0; go to RUN.
- IDLE or DONE, start=0 at an edge: go to (or stay in) IDLE.
- RUN, each edge:
  - add chunk[counter] of A, effective B chunk and carry;
  - write the CHUNK-bit result into the matching sum bits;
  - update the carry register; counter++.
  - After the edge that processes chunk N-1: cout = final carry; go to DONE.
- start while in RUN is ignored: operands are unchanged and nothing is queued.
- Latency: start sampled at edge E0 gives done=1 in the cycle after edge EN (N clocks). Back-to-back: start held high in the DONE cycle begins the next operation at that edge, giving one result every N+1 clocks.
- busy=1 exactly in RUN. done=1 exactly in DONE, for one cycle.
- sum and cout:
  - hold their last result from DONE until the next accepted start;
  - sum bits are updated chunk by chunk during RUN;
  - are only meaningful while done=1 or after it.
- Arithmetic:
  - {cout, sum} = a + b + cin when sub=0;
  - {cout, sum} = a + ~b + 1 when sub=1;
  - modulo 2^WIDTH with cout as bit WIDTH.
- CHUNK == WIDTH degenerates to N=1: done one cycle after the start edge.

Optional Feature:
- Macro SERIAL_ADDER_OVF_EN.
- Defined: adds output port ovf (1 bit), the signed two's-complement overflow.
  - ovf = carry into MSB XOR carry out of MSB, captured at the final chunk.
  - Reset value 0; holds with sum.
- Undefined: no ovf port and no overflow logic; all other behaviour is identical.

Test Plan (WIDTH=8, CHUNK=2, so N=4):
- Reset then idle: rst_n low for 2 cycles, then high with start=0 -> busy=0, done=0, sum=8'h00, cout=0 throughout.
- Add with carry wrap: a=8'hFF, b=8'h01, cin=0, sub=0, start pulse -> busy high 4 cycles; done pulse in 5th cycle with sum=8'h00, cout=1; with OVF_EN, ovf=0.
- Subtract: a=8'h05, b=8'h07, sub=1, cin=1 (ignored) -> done after 4 cycles with sum=8'hFE, cout=0 (borrow); second run a=8'h7F, b=8'h80, sub=1 -> sum=8'hFF, cout=0, ovf=1.
- Signed overflow and start ignored while busy: a=8'h7F, b=8'h01, cin=0, add -> sum=8'h80, cout=0, ovf=1. Asserting start with a=8'h11 during RUN changes nothing, and only one done pulse occurs.
- Back-to-back: start held high across DONE with new operands a=8'h10, b=8'h20, cin=1 -> second done exactly 5 cycles after the first, with sum=8'h31, cout=0.
- Reset mid-operation: drop rst_n two cycles into RUN -> outputs clear immediately and no done pulse. A fresh start afterwards with a=8'h03, b=8'h04 gives sum=8'h07 after 4 cycles.
